// File: rtl/id_imm_ctrl.sv
// Decode-stage front end for the immediate extender.
// A two-entry skid buffer (head + skid) sits between IF and EX. The head
// entry is decoded combinationally into the sext op select and the
// immediate-valid and illegal flags. The buffer stores only the raw
// instruction and PC; decode is never cached.
module id_imm_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = 'h13
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_inst_i,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic [2:0]      sext_op_o,
  output logic            imm_en_o,
  output logic            illegal_o
);

  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            in_ready_q;
  logic [XLEN-1:0] h_inst_q, h_inst_d, h_pc_q, h_pc_d;
  logic [XLEN-1:0] s_inst_q, s_inst_d, s_pc_q, s_pc_d;
  logic            in_fire, out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = (state_q != EMPTY) & out_ready_i;

  // State, ready flop and entry storage.
  // in_ready is re-registered from the next state so that out_ready_i has
  // no combinational path to in_ready_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      h_inst_q   <= NOP_INST;
      h_pc_q     <= '0;
      s_inst_q   <= NOP_INST;
      s_pc_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      h_inst_q   <= h_inst_d;
      h_pc_q     <= h_pc_d;
      s_inst_q   <= s_inst_d;
      s_pc_q     <= s_pc_d;
    end
  end

  // Next occupancy and entry movement; flush wins and drops the same-cycle input.
  always_comb begin
    state_d  = state_q;
    h_inst_d = h_inst_q;
    h_pc_d   = h_pc_q;
    s_inst_d = s_inst_q;
    s_pc_d   = s_pc_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d  = ONE;
          h_inst_d = in_inst_i;
          h_pc_d   = in_pc_i;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            h_inst_d = in_inst_i;
            h_pc_d   = in_pc_i;
          end else if (in_fire) begin
            state_d  = TWO;
            s_inst_d = in_inst_i;
            s_pc_d   = in_pc_i;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: if (out_fire) begin
          state_d  = ONE;
          h_inst_d = s_inst_q;
          h_pc_d   = s_pc_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs: head entry and its decode, forced to NOP/zero while not valid.
  always_comb begin
    out_valid_o = (state_q != EMPTY);
    in_ready_o  = in_ready_q;
    inst_o      = NOP_INST;
    pc_o        = '0;
    sext_op_o   = 3'd0;
    imm_en_o    = 1'b0;
    illegal_o   = 1'b0;
    if (out_valid_o) begin
      inst_o = h_inst_q;
      pc_o   = h_pc_q;
      case (h_inst_q[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: imm_en_o = 1'b1;
        7'b0100011: begin sext_op_o = 3'd1; imm_en_o = 1'b1; end
        7'b1100011: begin sext_op_o = 3'd2; imm_en_o = 1'b1; end
        7'b1101111: begin sext_op_o = 3'd3; imm_en_o = 1'b1; end
        7'b0110111, 7'b0010111: begin sext_op_o = 3'd4; imm_en_o = 1'b1; end
        7'b0110011: imm_en_o = 1'b0;
        default:    illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Directed bench for id_imm_ctrl: reset, streaming, stall, flush, decode.
module tb_id_imm_ctrl;
  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic        in_valid_i = 1'b0, flush_i = 1'b0, out_ready_i = 1'b0;
  logic [31:0] in_inst_i = '0, in_pc_i = '0;
  logic        in_ready_o, out_valid_o, imm_en_o, illegal_o;
  logic [31:0] inst_o, pc_o;
  logic [2:0]  sext_op_o;
  int          n_chk = 0, n_fail = 0;

  id_imm_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_inst_i(in_inst_i), .in_pc_i(in_pc_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .inst_o(inst_o), .pc_o(pc_o), .sext_op_o(sext_op_o),
    .imm_en_o(imm_en_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge; inputs change and outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid_i = v; in_inst_i = inst; in_pc_i = pc;
  endtask

  // full head check: valid, inst, pc, op, imm_en, illegal
  task automatic head(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [2:0] op, input logic imm, input logic ill);
    chk({tag, ".vld"}, {31'd0, out_valid_o}, 32'd1);
    chk({tag, ".inst"}, inst_o, inst);
    chk({tag, ".pc"}, pc_o, pc);
    chk({tag, ".op"}, {29'd0, sext_op_o}, {29'd0, op});
    chk({tag, ".imm"}, {31'd0, imm_en_o}, {31'd0, imm});
    chk({tag, ".ill"}, {31'd0, illegal_o}, {31'd0, ill});
  endtask

  task automatic idle(input string tag);
    chk({tag, ".vld"}, {31'd0, out_valid_o}, 32'd0);
    chk({tag, ".inst"}, inst_o, 32'h13);
    chk({tag, ".rdy"}, {31'd0, in_ready_o}, 32'd1);
  endtask

  initial begin
    // reset state
    #12;
    idle("rst");
    chk("rst.pc", pc_o, 32'd0);
    chk("rst.op", {29'd0, sext_op_o}, 32'd0);
    chk("rst.imm", {31'd0, imm_en_o}, 32'd0);
    chk("rst.ill", {31'd0, illegal_o}, 32'd0);
    @(negedge clk_i); rst_n_i = 1'b1;
    tick();

    // streaming, no bubbles
    out_ready_i = 1'b1;
    drive(1, 32'h00500093, 32'h0); tick();
    head("s0", 32'h00500093, 32'h0, 3'd0, 1, 0);
    drive(1, 32'h00112023, 32'h4); tick();
    head("s1", 32'h00112023, 32'h4, 3'd1, 1, 0);
    drive(0, 32'h0, 32'h0); tick();
    idle("s2");

    // stall: three instructions, third held by IF
    out_ready_i = 1'b0;
    drive(1, 32'h0000006F, 32'h10); tick();
    head("st0", 32'h0000006F, 32'h10, 3'd3, 1, 0);
    chk("st0.rdy", {31'd0, in_ready_o}, 32'd1);
    drive(1, 32'h00000063, 32'h14); tick();
    chk("st1.rdy", {31'd0, in_ready_o}, 32'd0);
    head("st1", 32'h0000006F, 32'h10, 3'd3, 1, 0);
    drive(1, 32'h00001037, 32'h18); tick();
    chk("st2.rdy", {31'd0, in_ready_o}, 32'd0);
    head("st2", 32'h0000006F, 32'h10, 3'd3, 1, 0);
    out_ready_i = 1'b1; tick();                 // TWO & out_fire -> skid becomes head
    head("st3", 32'h00000063, 32'h14, 3'd2, 1, 0);
    chk("st3.rdy", {31'd0, in_ready_o}, 32'd1);
    tick();                                     // ONE, in_fire & out_fire -> new head
    head("st4", 32'h00001037, 32'h18, 3'd4, 1, 0);
    drive(0, 32'h0, 32'h0); tick();
    idle("st5");

    // flush with occupancy TWO and a pending input
    out_ready_i = 1'b0;
    drive(1, 32'h00000003, 32'h20); tick();
    drive(1, 32'h00000067, 32'h24); tick();
    chk("fl0.rdy", {31'd0, in_ready_o}, 32'd0);
    drive(1, 32'h00000017, 32'h28); flush_i = 1'b1; tick();
    flush_i = 1'b0; drive(0, 32'h0, 32'h0);
    idle("fl1");
    // flush with occupancy ONE and an accepted input: input dropped
    drive(1, 32'h00000003, 32'h30); tick();
    head("fl2", 32'h00000003, 32'h30, 3'd0, 1, 0);
    drive(1, 32'h00000017, 32'h34); flush_i = 1'b1; tick();
    flush_i = 1'b0; drive(0, 32'h0, 32'h0);
    idle("fl3");
    tick();
    idle("fl4");

    // decode sweep, streaming
    out_ready_i = 1'b1;
    drive(1, 32'h00B50533, 32'h40); tick();
    head("d0", 32'h00B50533, 32'h40, 3'd0, 0, 0);
    drive(1, 32'h0000007F, 32'h44); tick();
    head("d1", 32'h0000007F, 32'h44, 3'd0, 0, 1);
    drive(1, 32'h00000067, 32'h48); tick();
    head("d2", 32'h00000067, 32'h48, 3'd0, 1, 0);
    drive(1, 32'h00000017, 32'h4C); tick();
    head("d3", 32'h00000017, 32'h4C, 3'd4, 1, 0);
    drive(1, 32'h00000003, 32'h50); tick();
    head("d4", 32'h00000003, 32'h50, 3'd0, 1, 0);
    drive(0, 32'h0, 32'h0); tick();
    idle("d5");

    // asynchronous reset mid-stream with occupancy TWO
    out_ready_i = 1'b0;
    drive(1, 32'h00500093, 32'h60); tick();
    drive(1, 32'h00112023, 32'h64); tick();
    chk("ar0.rdy", {31'd0, in_ready_o}, 32'd0);
    rst_n_i = 1'b0; #1;
    idle("ar1");
    chk("ar1.pc", pc_o, 32'd0);
    drive(0, 32'h0, 32'h0);
    @(negedge clk_i); rst_n_i = 1'b1;
    tick();
    idle("ar2");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
